// File: rtl/round_sequencer.sv
// SHA-256 round sequencer: accepts 512-bit blocks, streams W_t/K_t to the round
// datapath, and folds the returned working variables into the running hash.
module round_sequencer #(
   parameter logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   input  logic [31:0]  cmp_a,
   input  logic [31:0]  cmp_b,
   input  logic [31:0]  cmp_c,
   input  logic [31:0]  cmp_d,
   input  logic [31:0]  cmp_e,
   input  logic [31:0]  cmp_f,
   input  logic [31:0]  cmp_g,
   input  logic [31:0]  cmp_h,
   output logic         cmp_en,
   output logic         cmp_init,
   output logic [31:0]  cmp_w,
   output logic [31:0]  cmp_k,
   output logic [31:0]  hash0,
   output logic [31:0]  hash1,
   output logic [31:0]  hash2,
   output logic [31:0]  hash3,
   output logic [31:0]  hash4,
   output logic [31:0]  hash5,
   output logic [31:0]  hash6,
   output logic [31:0]  hash7,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         busy
);

   // state  | meaning
   // IDLE   | waiting for a block, blk_ready high
   // INIT   | datapath loads A..H from the hash registers
   // ROUNDS | 64 compression rounds, one W_t/K_t pair per cycle
   // FINAL  | feed-forward add of A..H into the hash, then back to IDLE
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INIT   = 2'd1,
      ROUNDS = 2'd2,
      FINAL  = 2'd3
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [5:0]   round;
   logic [31:0]  win [16];
   logic [31:0]  hash [8];
   logic [31:0]  cmp_x [8];
   logic [31:0]  w_next;
   logic         accept;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   function automatic logic [31:0] k_rom(input logic [5:0] idx);
      k_rom = 32'h0;
      case (idx)
         6'd0:  k_rom = 32'h428a2f98;
         6'd1:  k_rom = 32'h71374491;
         6'd2:  k_rom = 32'hb5c0fbcf;
         6'd3:  k_rom = 32'he9b5dba5;
         6'd4:  k_rom = 32'h3956c25b;
         6'd5:  k_rom = 32'h59f111f1;
         6'd6:  k_rom = 32'h923f82a4;
         6'd7:  k_rom = 32'hab1c5ed5;
         6'd8:  k_rom = 32'hd807aa98;
         6'd9:  k_rom = 32'h12835b01;
         6'd10: k_rom = 32'h243185be;
         6'd11: k_rom = 32'h550c7dc3;
         6'd12: k_rom = 32'h72be5d74;
         6'd13: k_rom = 32'h80deb1fe;
         6'd14: k_rom = 32'h9bdc06a7;
         6'd15: k_rom = 32'hc19bf174;
         6'd16: k_rom = 32'he49b69c1;
         6'd17: k_rom = 32'hefbe4786;
         6'd18: k_rom = 32'h0fc19dc6;
         6'd19: k_rom = 32'h240ca1cc;
         6'd20: k_rom = 32'h2de92c6f;
         6'd21: k_rom = 32'h4a7484aa;
         6'd22: k_rom = 32'h5cb0a9dc;
         6'd23: k_rom = 32'h76f988da;
         6'd24: k_rom = 32'h983e5152;
         6'd25: k_rom = 32'ha831c66d;
         6'd26: k_rom = 32'hb00327c8;
         6'd27: k_rom = 32'hbf597fc7;
         6'd28: k_rom = 32'hc6e00bf3;
         6'd29: k_rom = 32'hd5a79147;
         6'd30: k_rom = 32'h06ca6351;
         6'd31: k_rom = 32'h14292967;
         6'd32: k_rom = 32'h27b70a85;
         6'd33: k_rom = 32'h2e1b2138;
         6'd34: k_rom = 32'h4d2c6dfc;
         6'd35: k_rom = 32'h53380d13;
         6'd36: k_rom = 32'h650a7354;
         6'd37: k_rom = 32'h766a0abb;
         6'd38: k_rom = 32'h81c2c92e;
         6'd39: k_rom = 32'h92722c85;
         6'd40: k_rom = 32'ha2bfe8a1;
         6'd41: k_rom = 32'ha81a664b;
         6'd42: k_rom = 32'hc24b8b70;
         6'd43: k_rom = 32'hc76c51a3;
         6'd44: k_rom = 32'hd192e819;
         6'd45: k_rom = 32'hd6990624;
         6'd46: k_rom = 32'hf40e3585;
         6'd47: k_rom = 32'h106aa070;
         6'd48: k_rom = 32'h19a4c116;
         6'd49: k_rom = 32'h1e376c08;
         6'd50: k_rom = 32'h2748774c;
         6'd51: k_rom = 32'h34b0bcb5;
         6'd52: k_rom = 32'h391c0cb3;
         6'd53: k_rom = 32'h4ed8aa4a;
         6'd54: k_rom = 32'h5b9cca4f;
         6'd55: k_rom = 32'h682e6ff3;
         6'd56: k_rom = 32'h748f82ee;
         6'd57: k_rom = 32'h78a5636f;
         6'd58: k_rom = 32'h84c87814;
         6'd59: k_rom = 32'h8cc70208;
         6'd60: k_rom = 32'h90befffa;
         6'd61: k_rom = 32'ha4506ceb;
         6'd62: k_rom = 32'hbef9a3f7;
         6'd63: k_rom = 32'hc67178f2;
      endcase
   endfunction

   assign cmp_x[0] = cmp_a;
   assign cmp_x[1] = cmp_b;
   assign cmp_x[2] = cmp_c;
   assign cmp_x[3] = cmp_d;
   assign cmp_x[4] = cmp_e;
   assign cmp_x[5] = cmp_f;
   assign cmp_x[6] = cmp_g;
   assign cmp_x[7] = cmp_h;

   // W_{t+16} from the sliding window, which always holds W_t..W_{t+15}
   assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

   always_comb begin
      state_nxt = state;
      blk_ready = 1'b0;
      accept    = 1'b0;
      cmp_en    = 1'b0;
      cmp_init  = 1'b0;
      cmp_w     = 32'h0;
      cmp_k     = 32'h0;
      case (state)
         IDLE: begin
            blk_ready = 1'b1;
            if (blk_valid) begin
               accept    = 1'b1;
               state_nxt = INIT;
            end
         end
         INIT: begin
            cmp_en    = 1'b1;
            cmp_init  = 1'b1;
            state_nxt = ROUNDS;
         end
         ROUNDS: begin
            cmp_en = 1'b1;
            cmp_w  = win[0];
            cmp_k  = k_rom(round);
            if (round == 6'd63) begin
               state_nxt = FINAL;
            end
         end
         FINAL: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         round        <= 6'd0;
         digest_valid <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            hash[i] <= IV[255-32*i -: 32];
         end
         for (int i = 0; i < 16; i++) begin
            win[i] <= 32'h0;
         end
      end else begin
         state        <= state_nxt;
         digest_valid <= (state == FINAL);
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int i = 0; i < 16; i++) begin
                     win[i] <= blk_data[511-32*i -: 32];
                  end
                  if (blk_first) begin
                     for (int i = 0; i < 8; i++) begin
                        hash[i] <= IV[255-32*i -: 32];
                     end
                  end
               end
            end
            INIT: begin
               round <= 6'd0;
            end
            ROUNDS: begin
               for (int i = 0; i < 15; i++) begin
                  win[i] <= win[i+1];
               end
               win[15] <= w_next;
               round   <= round + 6'd1;
            end
            FINAL: begin
               for (int i = 0; i < 8; i++) begin
                  hash[i] <= hash[i] + cmp_x[i];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign hash0  = hash[0];
   assign hash1  = hash[1];
   assign hash2  = hash[2];
   assign hash3  = hash[3];
   assign hash4  = hash[4];
   assign hash5  = hash[5];
   assign hash6  = hash[6];
   assign hash7  = hash[7];
   assign digest = {hash[0], hash[1], hash[2], hash[3], hash[4], hash[5], hash[6], hash[7]};
   assign busy   = (state != IDLE);

endmodule
